// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// Oversampling UART receiver front-end. Synchronises the raw RX pin, validates
// start bits, recovers 8-bit frames (LSB first, optional parity, one stop bit)
// and hands each byte plus its error flags to the downstream core over a
// valid/ready handshake.
//
// Optional build macro:
//   UART_RX_MAJORITY_VOTE_EN - each bit (including start validation) is the
//   2-of-3 vote of rxs at the decision tick and the two ticks before it.
//   When undefined, a single rxs sample at the decision tick is used.
//
// Parameters:
//   OVERSAMPLE : sample ticks per bit (even, >= 4)
//   DIV_WIDTH  : width of the baud prescaler divisor
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   rx         in   raw asynchronous serial input, idles high
//   divisor    in   clk cycles per sample tick minus 1 (latched at start)
//   parity_en  in   expect parity bit after the data bits (latched at start)
//   parity_odd in   1 = odd parity, 0 = even (latched at start)
//   data_out   out  received byte
//   data_valid out  data_out and flags are valid
//   data_ready in   consumer accepts the byte
//   frame_err  out  stop bit sampled 0
//   parity_err out  parity mismatch
//   break_det  out  data, parity (if enabled) and stop all sampled 0
//   overrun    out  one-cycle pulse: a completed byte was discarded
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int              TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_DEC = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   TICK_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;

    logic                   r_sync1;
    logic                   r_rxs;

    logic [DIV_WIDTH-1:0]   r_presc;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [TW-1:0]          r_tcnt;
    logic [2:0]             r_bcnt;
    logic                   r_par_en;
    logic                   r_par_odd;
    logic                   r_par_bit;
    logic [7:0]             r_shift;

    logic                   w_tick;
    logic                   w_active;
    logic                   w_dec;
    logic                   w_bit;
    logic                   w_detect;
    logic                   w_shift_en;
    logic                   w_par_cap;
    logic                   w_complete;
    logic                   w_par_exp;
    logic                   w_ferr;
    logic                   w_perr;
    logic                   w_brk;

    // ---- synchronizer: idles (and resets) to the line-idle level ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    // ---- tick and decision-point generation ----
    assign w_tick   = (r_presc == r_div);
    assign w_active = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
    // Decision is the OVERSAMPLE/2-th tick of the bit (counter is pre-increment).
    assign w_dec    = w_active && w_tick && (r_tcnt == TICK_DEC);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_hist;

    function automatic logic f_maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Holds rxs from the two most recent ticks; at the decision tick these are
    // ticks OVERSAMPLE/2-2 and OVERSAMPLE/2-1. Seeded with the start level.
    always_ff @(posedge clk) begin
        if (w_detect) begin
            r_hist <= 2'b00;
        end else if (w_tick) begin
            r_hist <= {r_hist[0], r_rxs};
        end
    end

    assign w_bit = f_maj(r_hist[1], r_hist[0], r_rxs);
`else
    assign w_bit = r_rxs;
`endif

    // ---- FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_detect   = 1'b0;
        w_shift_en = 1'b0;
        w_par_cap  = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_detect   = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_dec) begin
                    w_state_nx = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_dec) begin
                    w_shift_en = 1'b1;
                    if (r_bcnt == 3'd7) begin
                        w_state_nx = r_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_dec) begin
                    w_par_cap  = 1'b1;
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (w_dec) begin
                    w_complete = 1'b1;
                    // Leaving at mid-stop lets the next start edge be caught early.
                    w_state_nx = w_bit ? S_IDLE : S_BRK_WAIT;
                end
            end
            S_BRK_WAIT: begin
                if (r_rxs) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ---- prescaler, tick-in-bit and data-bit counters ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
        end else if (w_detect) begin
            r_presc <= '0;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
        end else if (w_active) begin
            if (w_tick) begin
                r_presc <= '0;
                r_tcnt  <= (r_tcnt == TICK_END) ? '0 : r_tcnt + TW'(1);
            end else begin
                r_presc <= r_presc + DIV_WIDTH'(1);
            end
            if (w_shift_en) begin
                r_bcnt <= r_bcnt + 3'd1;
            end
        end
    end

    // ---- frame datapath: latched config, shift register, parity sample ----
    always_ff @(posedge clk) begin
        if (w_detect) begin
            r_div     <= divisor;
            r_par_en  <= parity_en;
            r_par_odd <= parity_odd;
            r_par_bit <= 1'b0;
        end
        if (w_shift_en) begin
            r_shift <= {w_bit, r_shift[7:1]};
        end
        if (w_par_cap) begin
            r_par_bit <= w_bit;
        end
    end

    // Flags for the byte completing this cycle; w_bit is the stop sample here.
    assign w_par_exp = (^r_shift) ^ r_par_odd;
    assign w_ferr    = ~w_bit;
    assign w_perr    = r_par_en & (r_par_bit ^ w_par_exp);
    assign w_brk     = (r_shift == 8'h00) & ~w_bit & (~r_par_en | ~r_par_bit);

    // ---- output register and handshake ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= r_shift;
                    frame_err  <= w_ferr;
                    parity_err <= w_perr;
                    break_det  <= w_brk;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] divisor = 16'd0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        data_ready = 1'b1;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_err;
    logic        parity_err;
    logic        break_det;
    logic        overrun;

    uart_rx_sampler #(.OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .divisor    (divisor),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .break_det  (break_det),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    int   n_ovr = 0;
    int   rise_cyc = -1;
    int   t0 = 0;
    int   x0;
    int   o0;
    logic [7:0] x_data = 8'h00;
    logic x_ferr = 1'b0;
    logic x_perr = 1'b0;
    logic x_brk = 1'b0;
    logic prev_v = 1'b0;

    // Observes handshakes, overrun pulses and the cycle data_valid rises.
    always @(negedge clk) begin
        if (data_valid && !prev_v) rise_cyc = cyc;
        if (data_valid && data_ready) begin
            n_xfer = n_xfer + 1;
            x_data = data_out;
            x_ferr = frame_err;
            x_perr = parity_err;
            x_brk  = break_det;
        end
        if (overrun) n_ovr = n_ovr + 1;
        prev_v = data_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 data_ready = v;
    endtask

    // Drives one frame, cpb clk cycles per bit. Bit gbit is inverted for one
    // cycle at its centre (-1 = no glitch). t0 = cycle the start bit is driven.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stopv, input int cpb, input int gbit);
        logic [10:0] bits;
        int nb;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stopv;
            nb = 11;
        end else begin
            bits[9] = stopv;
            nb = 10;
        end
        rise_cyc = -1;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < cpb; j++) begin
                @(negedge clk);
                if (b == 0 && j == 0) t0 = cyc;
                rx = bits[b] ^ ((b == gbit) && (j == cpb / 2));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_brk", break_det, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        wait_cyc(5);

        // Plain 0xA5, divisor 0: valid 155 cycles after rx falls
        x0 = n_xfer;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, -1);
        wait_cyc(8);
        chk("a5_count", n_xfer - x0, 1);
        chk("a5_data", x_data, 8'hA5);
        chk("a5_ferr", x_ferr, 1'b0);
        chk("a5_perr", x_perr, 1'b0);
        chk("a5_brk", x_brk, 1'b0);
        chk("a5_latency", rise_cyc - t0, 155);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-cycle glitch exactly at a decision point is outvoted
        x0 = n_xfer;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, 2);
        wait_cyc(8);
        chk("glitch_count", n_xfer - x0, 1);
        chk("glitch_data", x_data, 8'hA5);
        chk("glitch_latency", rise_cyc - t0, 155);
        x0 = n_xfer;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, 1);
        wait_cyc(8);
        chk("glitch1_data", x_data, 8'hA5);
`endif

        // Even parity: 0x3C has four ones, so expected parity bit is 0
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1);
        wait_cyc(8);
        chk("par_bad_data", x_data, 8'h3C);
        chk("par_bad_perr", x_perr, 1'b1);
        chk("par_bad_ferr", x_ferr, 1'b0);
        chk("par_latency", rise_cyc - t0, 171);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1);
        wait_cyc(8);
        chk("par_ok_data", x_data, 8'h3C);
        chk("par_ok_perr", x_perr, 1'b0);
        parity_odd = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1);
        wait_cyc(8);
        chk("par_odd_perr", x_perr, 1'b0);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // Divisor 1: two clk cycles per tick
        divisor = 16'd1;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 32, -1);
        wait_cyc(8);
        chk("div1_data", x_data, 8'h96);
        chk("div1_latency", rise_cyc - t0, 307);
        divisor = 16'd0;
        wait_cyc(4);

        // False start: rx low for 4 cycles only
        x0 = n_xfer;
        @(negedge clk) rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        wait_cyc(40);
        chk("false_count", n_xfer - x0, 0);
        chk("false_valid", data_valid, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16, -1);
        wait_cyc(8);
        chk("after_false_data", x_data, 8'hC3);
        chk("after_false_latency", rise_cyc - t0, 155);

        // Stop bit 0 with non-zero data: frame error, no break
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 16, -1);
        rx = 1'b1;
        wait_cyc(20);
        chk("ferr_data", x_data, 8'h81);
        chk("ferr_ferr", x_ferr, 1'b1);
        chk("ferr_brk", x_brk, 1'b0);

        // Break: rx low for 20 bit times
        x0 = n_xfer;
        rise_cyc = -1;
        @(negedge clk) rx = 1'b0;
        t0 = cyc;
        repeat (319) @(negedge clk);
        chk("brk_count", n_xfer - x0, 1);
        chk("brk_data", x_data, 8'h00);
        chk("brk_ferr", x_ferr, 1'b1);
        chk("brk_brk", x_brk, 1'b1);
        chk("brk_perr", x_perr, 1'b0);
        chk("brk_latency", rise_cyc - t0, 155);
        rx = 1'b1;
        wait_cyc(40);
        chk("brk_no_second", n_xfer - x0, 1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 16, -1);
        wait_cyc(8);
        chk("after_brk_data", x_data, 8'h7E);
        chk("after_brk_count", n_xfer - x0, 2);

        // Overrun: two back-to-back bytes with the consumer stalled
        set_ready(1'b0);
        x0 = n_xfer;
        o0 = n_ovr;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16, -1);
        wait_cyc(8);
        chk("ovr_pulses", n_ovr - o0, 1);
        chk("ovr_hold_data", data_out, 8'h11);
        chk("ovr_hold_valid", data_valid, 1'b1);
        chk("ovr_no_xfer", n_xfer - x0, 0);
        set_ready(1'b1);
        wait_cyc(20);
        chk("ovr_xfer_count", n_xfer - x0, 1);
        chk("ovr_xfer_data", x_data, 8'h11);
        chk("ovr_valid_clear", data_valid, 1'b0);

        // Reset mid data bit with a flagged byte pending
        set_ready(1'b0);
        parity_en = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1);
        wait_cyc(8);
        chk("pre_rst_perr", parity_err, 1'b1);
        parity_en = 1'b0;
        @(negedge clk) rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", data_valid, 1'b0);
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_perr", parity_err, 1'b0);
        chk("mid_rst_ferr", frame_err, 1'b0);
        chk("mid_rst_brk", break_det, 1'b0);
        chk("mid_rst_ovr", overrun, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        set_ready(1'b1);
        wait_cyc(10);
        x0 = n_xfer;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1);
        wait_cyc(8);
        chk("post_rst_count", n_xfer - x0, 1);
        chk("post_rst_data", x_data, 8'h5A);
        chk("post_rst_latency", rise_cyc - t0, 155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
